// File: rtl/poly_square_osc_if.sv
// Voice-programming bus plus the sample/write/allowed handshake toward the audio controller.
`timescale 1ns/1ps

interface poly_square_osc_if #(
  parameter int PERIOD_W = 20,
  parameter int AMP_W    = 8,
  parameter int SAMPLE_W = 32
);
  logic                voice_load;
  logic [3:0]          voice_sel;
  logic [PERIOD_W-1:0] voice_period;
  logic [AMP_W-1:0]    voice_amp;
  logic                audio_out_allowed;
  logic [SAMPLE_W-1:0] sample_out;
  logic                write_audio_out;

  modport master (
    output voice_load, voice_sel, voice_period, voice_amp, audio_out_allowed,
    input  sample_out, write_audio_out
  );

  modport slave (
    input  voice_load, voice_sel, voice_period, voice_amp, audio_out_allowed,
    output sample_out, write_audio_out
  );
endinterface

// File: rtl/poly_square_osc.sv
// Polyphonic square-wave generator: NUM_VOICES programmable voices mixed into one signed,
// left-aligned sample delivered once per SAMPLE_DIV clocks with overrun detection.
`timescale 1ns/1ps

module poly_square_osc #(
  parameter int NUM_VOICES = 4,
  parameter int PERIOD_W   = 20,
  parameter int AMP_W      = 8,
  parameter int SAMPLE_W   = 32,
  parameter int SAMPLE_DIV = 1042
) (
  input  logic                  clk,
  input  logic                  reset_n,
  poly_square_osc_if.slave      bus,
  input  logic                  overrun_clr,
  output logic [NUM_VOICES-1:0] voice_active,
  output logic                  overrun
);
  localparam int MW    = AMP_W + 1 + $clog2(NUM_VOICES);
  localparam int SHIFT = SAMPLE_W - MW;
  localparam int DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

  logic [PERIOD_W-1:0]        period [NUM_VOICES];
  logic [AMP_W-1:0]           amp    [NUM_VOICES];
  logic [PERIOD_W-1:0]        cnt    [NUM_VOICES];
  logic [NUM_VOICES-1:0]      phase_neg;
  logic [NUM_VOICES-1:0]      load_hit;
  logic signed [MW-1:0]       mix;
  logic signed [SAMPLE_W-1:0] mix_wide;
  logic [DIV_W-1:0]           div_cnt;
  logic                       tick;
  logic                       pending;
  logic                       write_now;

  // Out-of-range selects match no voice, so they are ignored without extra logic.
  always_comb begin
    load_hit = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      load_hit[i] = bus.voice_load && (bus.voice_sel == 4'(i));
    end
  end

  always_comb begin
    voice_active = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      voice_active[i] = (period[i] != '0);
    end
  end

  // A load takes priority over a wrap on the same voice and restarts it in the + phase.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        period[i] <= '0;
        amp[i]    <= '0;
        cnt[i]    <= '0;
      end
      phase_neg <= '0;
    end else begin
      for (int i = 0; i < NUM_VOICES; i++) begin
        if (load_hit[i]) begin
          period[i]    <= bus.voice_period;
          amp[i]       <= bus.voice_amp;
          cnt[i]       <= '0;
          phase_neg[i] <= 1'b0;
        end else if (period[i] == '0) begin
          cnt[i]       <= '0;
          phase_neg[i] <= 1'b0;
        end else if (cnt[i] == period[i] - PERIOD_W'(1)) begin
          cnt[i]       <= '0;
          phase_neg[i] <= ~phase_neg[i];
        end else begin
          cnt[i] <= cnt[i] + PERIOD_W'(1);
        end
      end
    end
  end

  // Off voices contribute 0; MW is wide enough that the sum never overflows.
  always_comb begin
    mix = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (period[i] != '0) begin
        if (phase_neg[i]) begin
          mix = mix - MW'(amp[i]);
        end else begin
          mix = mix + MW'(amp[i]);
        end
      end
    end
    mix_wide = SAMPLE_W'(mix) <<< SHIFT;
  end

  assign tick                = (div_cnt == DIV_LAST);
  assign write_now           = pending & bus.audio_out_allowed;
  assign bus.write_audio_out = write_now;

  // A tick always latches a fresh sample; a write in the same cycle consumed the old one.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt        <= '0;
      pending        <= 1'b0;
      bus.sample_out <= '0;
      overrun        <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      if (tick) begin
        bus.sample_out <= mix_wide;
        pending        <= 1'b1;
      end else if (write_now) begin
        pending <= 1'b0;
      end
      if (tick && pending && !write_now) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_poly_square_osc.sv
// Scoreboard bench for poly_square_osc: a time-based voice model predicts every written
// sample, and a negedge monitor pops and compares whenever the DUT strobes a write.
`timescale 1ns/1ps

module tb_poly_square_osc;
  localparam int NV         = 4;
  localparam int PERIOD_W   = 20;
  localparam int AMP_W      = 8;
  localparam int SAMPLE_W   = 32;
  localparam int SAMPLE_DIV = 1042;
  localparam int MW         = AMP_W + 1 + $clog2(NV);
  localparam int SHIFT      = SAMPLE_W - MW;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          overrun_clr;
  logic [NV-1:0] voice_active;
  logic          overrun;

  poly_square_osc_if #(.PERIOD_W(PERIOD_W), .AMP_W(AMP_W), .SAMPLE_W(SAMPLE_W)) bus ();

  poly_square_osc #(
    .NUM_VOICES(NV), .PERIOD_W(PERIOD_W), .AMP_W(AMP_W),
    .SAMPLE_W(SAMPLE_W), .SAMPLE_DIV(SAMPLE_DIV)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .overrun_clr  (overrun_clr),
    .voice_active (voice_active),
    .overrun      (overrun)
  );

  always #10 clk = ~clk;

  int                  n_checks = 0;
  int                  n_errors = 0;
  int                  m_edge;
  bit                  m_pending;
  bit                  m_overrun;
  bit                  m_write;
  bit                  m_tick;
  logic [SAMPLE_W-1:0] m_sample;
  logic [SAMPLE_W-1:0] m_new;
  int                  m_period    [NV];
  int                  m_amp       [NV];
  int                  m_load_edge [NV];
  logic [SAMPLE_W-1:0] exp_q [$];

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic resetModel();
    m_edge    = 0;
    m_pending = 0;
    m_overrun = 0;
    m_sample  = '0;
    exp_q.delete();
    for (int i = 0; i < NV; i++) begin
      m_period[i]    = 0;
      m_amp[i]       = 0;
      m_load_edge[i] = 0;
    end
  endtask

  // Phase of a voice is the parity of whole half-periods elapsed since it was loaded.
  function automatic logic [SAMPLE_W-1:0] expectedSample(input int n);
    longint mix = 0;
    for (int i = 0; i < NV; i++) begin
      if (m_period[i] != 0) begin
        if ((((n - m_load_edge[i]) / m_period[i]) % 2) == 1) mix -= m_amp[i];
        else mix += m_amp[i];
      end
    end
    return SAMPLE_W'(mix * (longint'(1) << SHIFT));
  endfunction

  function automatic logic [NV-1:0] expectedActive();
    logic [NV-1:0] a = '0;
    for (int i = 0; i < NV; i++) a[i] = (m_period[i] != 0);
    return a;
  endfunction

  // Reference model: advances on each clock edge from the inputs held during that cycle.
  always @(posedge clk) begin
    if (reset_n) begin
      m_edge++;
      m_write = m_pending && bus.audio_out_allowed;
      m_tick  = (m_edge % SAMPLE_DIV) == 0;
      if (m_tick) begin
        m_new = expectedSample(m_edge - 1);
        if (m_pending && !m_write && exp_q.size() > 0) exp_q[exp_q.size()-1] = m_new;
        else exp_q.push_back(m_new);
      end
      if (m_tick && m_pending && !m_write) m_overrun = 1;
      else if (overrun_clr) m_overrun = 0;
      if (m_tick) begin
        m_pending = 1;
        m_sample  = m_new;
      end else if (m_write) begin
        m_pending = 0;
      end
      if (bus.voice_load && bus.voice_sel < NV) begin
        m_period[bus.voice_sel]    = int'(bus.voice_period);
        m_amp[bus.voice_sel]       = int'(bus.voice_amp);
        m_load_edge[bus.voice_sel] = m_edge;
      end
    end
  end

  // Monitor: consumes one expected sample per observed write strobe.
  always @(negedge clk) begin
    if (!reset_n) begin
      checkOutput("rst_write", bus.write_audio_out, 1'b0);
      checkOutput("rst_sample", bus.sample_out, '0);
      checkOutput("rst_overrun", overrun, 1'b0);
      checkOutput("rst_active", voice_active, '0);
    end else begin
      checkOutput("write_strobe", bus.write_audio_out, m_pending && bus.audio_out_allowed);
      if (bus.write_audio_out === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("[TB] FAIL extra_write: actual=write expected=no_write at %0t", $time);
        end else begin
          checkOutput("written_sample", bus.sample_out, exp_q.pop_front());
        end
      end
      checkOutput("sample_hold", bus.sample_out, m_sample);
      checkOutput("overrun", overrun, m_overrun);
      checkOutput("voice_active", voice_active, expectedActive());
    end
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic waitTicks(input int k);
    repeat (k) begin
      stepCycle();
      while (m_edge % SAMPLE_DIV != 0) stepCycle();
    end
  endtask

  task automatic applyStimulus(input int sel, input int per, input int amp_v);
    bus.voice_load   = 1'b1;
    bus.voice_sel    = 4'(sel);
    bus.voice_period = PERIOD_W'(per);
    bus.voice_amp    = AMP_W'(amp_v);
    stepCycle();
    bus.voice_load   = 1'b0;
  endtask

  initial begin
    #3000000;
    n_errors++;
    $display("[TB] FAIL watchdog: actual=timeout expected=finish");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.voice_load        = 1'b0;
    bus.voice_sel         = '0;
    bus.voice_period      = '0;
    bus.voice_amp         = '0;
    bus.audio_out_allowed = 1'b0;
    overrun_clr           = 1'b0;
    #1 reset_n = 1'b0;
    resetModel();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    bus.audio_out_allowed = 1'b1;

    $display("[TB] idle after reset");
    while (m_edge < 1041) stepCycle();
    checkOutput("no_write_before_tick", bus.write_audio_out, 1'b0);
    stepCycle();
    checkOutput("first_write", bus.write_audio_out, 1'b1);
    checkOutput("first_sample_zero", bus.sample_out, '0);
    waitTicks(1);

    $display("[TB] single voice P=4 amp=100");
    applyStimulus(0, 4, 100);
    waitTicks(2);
    checkOutput("v0_sample_mag",
                (bus.sample_out == 32'h0C800000) || (bus.sample_out == 32'hF3800000), 1'b1);

    $display("[TB] two voices P=5 amp=255, staggered");
    applyStimulus(0, 5, 255);
    stepCycle();
    applyStimulus(1, 5, 255);
    checkOutput("active_0011", voice_active, 4'b0011);
    waitTicks(3);

    $display("[TB] overrun with allowed low");
    stepCycle();
    bus.audio_out_allowed = 1'b0;
    waitTicks(1);
    checkOutput("overrun_first_tick", overrun, 1'b0);
    waitTicks(1);
    checkOutput("overrun_second_tick", overrun, 1'b1);
    bus.audio_out_allowed = 1'b1;
    repeat (3) stepCycle();
    overrun_clr = 1'b1;
    stepCycle();
    overrun_clr = 1'b0;
    checkOutput("overrun_cleared", overrun, 1'b0);

    $display("[TB] tick coincident with write");
    bus.audio_out_allowed = 1'b0;
    waitTicks(1);
    while (m_edge % SAMPLE_DIV != SAMPLE_DIV - 1) stepCycle();
    bus.audio_out_allowed = 1'b1;
    stepCycle();
    checkOutput("coincident_overrun", overrun, 1'b0);
    checkOutput("coincident_new_pending", bus.write_audio_out, 1'b1);
    repeat (3) stepCycle();

    $display("[TB] ignored select, voice off, P=1");
    applyStimulus(7, 9, 50);
    checkOutput("sel7_ignored", voice_active, 4'b0011);
    applyStimulus(1, 0, 0);
    checkOutput("voice1_off", voice_active, 4'b0001);
    applyStimulus(2, 1, 30);
    waitTicks(2);

    $display("[TB] randomized traffic");
    for (int c = 0; c < 25000; c++) begin
      if ($urandom_range(0, 39) == 0) begin
        bus.voice_load   = 1'b1;
        bus.voice_sel    = 4'($urandom_range(0, 7));
        bus.voice_period = ($urandom_range(0, 7) == 0) ? '0 : PERIOD_W'($urandom_range(1, 40));
        bus.voice_amp    = AMP_W'($urandom);
      end else begin
        bus.voice_load = 1'b0;
      end
      if ($urandom_range(0, 1499) == 0) bus.audio_out_allowed = ~bus.audio_out_allowed;
      overrun_clr = ($urandom_range(0, 2999) == 0);
      stepCycle();
    end
    bus.voice_load = 1'b0;
    overrun_clr    = 1'b0;

    $display("[TB] reset mid-sample");
    applyStimulus(3, 7, 200);
    bus.audio_out_allowed = 1'b0;
    waitTicks(1);
    repeat (100) stepCycle();
    bus.audio_out_allowed = 1'b1;
    #2 reset_n = 1'b0;
    resetModel();
    #1;
    checkOutput("async_rst_write", bus.write_audio_out, 1'b0);
    checkOutput("async_rst_sample", bus.sample_out, '0);
    checkOutput("async_rst_active", voice_active, '0);
    checkOutput("async_rst_overrun", overrun, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    waitTicks(1);
    repeat (4) stepCycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/poly_square_osc.md
Name: poly_square_osc

Overview:
Polyphonic square-wave tone generator and mixer: the parametrised successor to the single-voice square oscillator that drives the audio codec path.
- Holds NUM_VOICES independently programmable voices, each with its own half-period and amplitude.
- Sums the voices into one signed sample.
- Delivers that sample at a fixed sample rate through the audio controller's write/allowed handshake, with overrun detection.
- Sits between the note/keyboard player logic and the audio controller's left/right inputs.

Parameters:
NUM_VOICES, 4, number of voices (1..16)
PERIOD_W, 20, width of half-period in clk cycles
AMP_W, 8, unsigned per-voice amplitude width
SAMPLE_W, 32, output sample width (must be >= AMP_W+1+clog2(NUM_VOICES))
SAMPLE_DIV, 1042, clk cycles per output sample (50 MHz / 48 kHz)

Ports:
clk  in  1  system clock (50 MHz)
reset_n  in  1  asynchronous active-low reset
voice_load  in  1  single-cycle strobe: program voice voice_sel
voice_sel  in  4  voice index; values >= NUM_VOICES ignored
voice_period  in  PERIOD_W  half-period in clk cycles; 0 = voice off
voice_amp  in  AMP_W  amplitude for programmed voice
audio_out_allowed  in  1  audio controller can accept a sample
sample_out  out  SAMPLE_W  signed mixed sample, left-aligned
write_audio_out  out  1  write strobe to audio controller
voice_active  out  NUM_VOICES  bit i = voice i has nonzero period
overrun  out  1  sticky: a sample was replaced before being written
overrun_clr  in  1  clears overrun

Behaviour:
- Reset (async, reset_n=0): all periods, amps and counters to 0; all phases to +; sample_out=0; write_audio_out=0; voice_active=0; overrun=0; sample divider=0; pending=0.
- Voice load (voice_load=1, voice_sel<NUM_VOICES), on that clk edge:
  - period[sel]<=voice_period, amp[sel]<=voice_amp, cnt[sel]<=0, phase[sel]<=+.
  - voice_active[sel] = (voice_period!=0), visible the next cycle.
  - voice_sel>=NUM_VOICES: no state change.
- Voice counter (per voice, period P!=0):
  - cnt increments each cycle.
  - When cnt==P-1: cnt<=0 and phase toggles. Output frequency = clk/(2P).
  - P=1 toggles every cycle.
  - P=0: cnt held 0, phase held +, contribution 0.
- Contribution: +amp when phase=+, -amp when phase=-, as signed (AMP_W+1)-bit values.
- Mix:
  - Signed sum of all contributions, width MW = AMP_W+1+clog2(NUM_VOICES); no saturation is needed at this width.
  - Sign-extend-free left alignment: sample = mix << (SAMPLE_W-MW), low bits 0.
- Sample divider:
  - Counts 0..SAMPLE_DIV-1, wrapping to 0.
  - Tick when the counter == SAMPLE_DIV-1.
  - On a tick, sample_out latches the mix computed from the current-cycle phases (registered; valid the cycle after the tick), and pending<=1.
- Handshake:
  - write_audio_out = pending & audio_out_allowed (combinational AND of registered pending).
  - When write_audio_out=1 at a clk edge, pending<=0; sample_out is unchanged until the next tick.
  - Each latched sample is written at most once.
- Overrun:
  - A tick while pending=1 and no write that cycle sets overrun (sticky); the new sample replaces the old one and pending stays 1.
  - A tick and a write in the same cycle: the write consumes the old sample, the new sample latches, pending=1, no overrun.
- overrun_clr=1 clears overrun. If a set condition occurs in the same cycle, set wins.
- Simultaneous load and wrap on the same voice: load wins (cnt=0, phase=+).
- Reset mid-operation: immediate return to reset state. Any sample not yet written is discarded; no write_audio_out glitch after reset assertion.

Test Plan:
- Reset then idle, audio_out_allowed=1: sample_out=0 throughout; first write_audio_out 1 cycle after cycle 1041; written sample=0.
- Load voice 0, P=4, amp=100, others off: phase + for 4 cycles, − for 4 (period 8). With MW=11, SAMPLE_W=32, latched sample = ±100<<21 = ±0x0C800000.
- Load voices 0 and 1 both P=5, amp=255; load voice 1 two cycles later: mixes alternate among +510, 0 and −510 (scaled); voice_active=4'b0011.
- Hold audio_out_allowed=0 across two ticks: overrun=1 at the second tick. Raise allowed: exactly one write of the newer sample. overrun_clr=1 → overrun=0.
- Tick coincident with a write (allowed rises exactly at the tick cycle): old sample written, new one pending, overrun stays 0.
- Load voice_sel=7 with NUM_VOICES=4: no state change. Load P=0 to an active voice: contribution 0 next cycle, voice_active bit clears. Assert reset_n=0 mid-sample: outputs return to 0 asynchronously.
